// File: rtl/threshold_editor_if.sv
// Handshake/bus bundle between the button layer, the threshold editor and the
// comparators. master = button layer side (drives controls, reads threshold);
// slave = threshold_editor side. Parameters must match the editor instance.
interface threshold_editor_if #(
    parameter int N_FIELDS = 3,
    parameter int FIELD_W  = 6
);
    localparam int SEL_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    logic                         adjust_en;
    logic                         unit_toggle_press_once;
    logic                         inc_press_once;
    logic                         dec_press_once;
    logic                         inc_held;
    logic                         dec_held;
    logic                         load_en;
    logic [N_FIELDS*FIELD_W-1:0]  load_value;
    logic [N_FIELDS*FIELD_W-1:0]  threshold;
    logic [SEL_W-1:0]             field_sel;
    logic                         editing;

    modport master (
        output adjust_en, unit_toggle_press_once, inc_press_once, dec_press_once,
               inc_held, dec_held, load_en, load_value,
        input  threshold, field_sel, editing
    );

    modport slave (
        input  adjust_en, unit_toggle_press_once, inc_press_once, dec_press_once,
               inc_held, dec_held, load_en, load_value,
        output threshold, field_sel, editing
    );
endinterface

// File: rtl/threshold_editor.sv
// threshold_editor: edits N_FIELDS packed modular counters (field 0 = LSBs).
// Ports: clk_100Hz, rst (async, active-high), bus (threshold_editor_if.slave):
//   button pulses/levels and load in; threshold, field_sel, editing out.
// Latency: one cycle from qualifying input to threshold. No backpressure.
// Optional macro THRESHOLD_SHADOW_COMMIT_EN: edits go to a shadow copy that is
// committed to threshold only when leaving EDIT.
module threshold_editor #(
    parameter int                        N_FIELDS     = 3,
    parameter int                        FIELD_W      = 6,
    parameter logic [N_FIELDS*FIELD_W-1:0] FIELD_MAX  = {6'd23, 6'd59, 6'd59},
    parameter logic [N_FIELDS*FIELD_W-1:0] RESET_VAL  = {6'd0, 6'd1, 6'd0},
    parameter int                        REPEAT_DELAY = 50,
    parameter int                        REPEAT_RATE  = 10,
    parameter int                        CARRY_MODE   = 0
) (
    input  logic              clk_100Hz,
    input  logic              rst,
    threshold_editor_if.slave bus
);
    localparam int SEL_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int TOT_W = N_FIELDS * FIELD_W;

    typedef enum logic {IDLE, EDIT} state_t;

    state_t           state;
    logic [TOT_W-1:0] thr_q;
    logic [SEL_W-1:0] sel_q;
    logic             edit_q;
    logic [15:0]      hold_cnt;

    logic [TOT_W-1:0] edit_base;
    logic [TOT_W-1:0] stepped;
    logic [TOT_W-1:0] clamped;
    logic             one_held;
    logic             rep_fire;
    logic             do_inc;
    logic             do_dec;
    logic             do_step;

`ifdef THRESHOLD_SHADOW_COMMIT_EN
    logic [TOT_W-1:0] shadow;
    assign edit_base = shadow;
`else
    assign edit_base = thr_q;
`endif

    assign bus.threshold = thr_q;
    assign bus.field_sel = sel_q;
    assign bus.editing   = edit_q;

    // The counter reloads to DELAY+1 after each rate step, so it fires at
    // DELAY, DELAY+RATE, DELAY+2*RATE, ... cycles after the press.
    assign one_held = bus.inc_held ^ bus.dec_held;
    assign rep_fire = (state == EDIT) && one_held &&
                      ((hold_cnt == 16'(REPEAT_DELAY)) ||
                       (hold_cnt == 16'(REPEAT_DELAY + REPEAT_RATE)));

    // A press pulse coinciding with a repeat tick is a single step; inc wins.
    assign do_inc  = bus.inc_press_once | (rep_fire & bus.inc_held);
    assign do_dec  = bus.dec_press_once | (rep_fire & bus.dec_held);
    assign do_step = do_inc | do_dec;

    // Step the selected field; with CARRY_MODE a wrap ripples upward within
    // the same cycle. Carry out of the top field is dropped.
    always_comb begin
        logic                go;
        logic                wrap;
        logic [FIELD_W-1:0]  v;
        logic [FIELD_W-1:0]  nv;
        logic [FIELD_W-1:0]  fmax;
        stepped = edit_base;
        go      = 1'b0;
        for (int i = 0; i < N_FIELDS; i++) begin
            v    = edit_base[i*FIELD_W +: FIELD_W];
            fmax = FIELD_MAX[i*FIELD_W +: FIELD_W];
            nv   = v;
            wrap = 1'b0;
            if (do_step && (sel_q == SEL_W'(i))) go = 1'b1;
            if (go) begin
                if (do_inc) begin
                    if (v == fmax) begin
                        nv   = '0;
                        wrap = 1'b1;
                    end else begin
                        nv = v + FIELD_W'(1);
                    end
                end else begin
                    if (v == '0) begin
                        nv   = fmax;
                        wrap = 1'b1;
                    end else begin
                        nv = v - FIELD_W'(1);
                    end
                end
                stepped[i*FIELD_W +: FIELD_W] = nv;
            end
            go = go & wrap & (CARRY_MODE != 0);
        end
    end

    // Bulk load clamps each field to its maximum.
    always_comb begin
        logic [FIELD_W-1:0] lv;
        logic [FIELD_W-1:0] fmax;
        clamped = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            lv   = bus.load_value[i*FIELD_W +: FIELD_W];
            fmax = FIELD_MAX[i*FIELD_W +: FIELD_W];
            clamped[i*FIELD_W +: FIELD_W] = (lv > fmax) ? fmax : lv;
        end
    end

    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            thr_q    <= RESET_VAL;
            sel_q    <= '0;
            edit_q   <= 1'b0;
            hold_cnt <= '0;
`ifdef THRESHOLD_SHADOW_COMMIT_EN
            shadow   <= RESET_VAL;
`endif
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (bus.load_en) thr_q <= clamped;
                    if (bus.adjust_en) begin
                        state  <= EDIT;
                        edit_q <= 1'b1;
                        sel_q  <= '0;
`ifdef THRESHOLD_SHADOW_COMMIT_EN
                        shadow <= bus.load_en ? clamped : thr_q;
`endif
                    end
                end
                EDIT: begin
                    if (!bus.adjust_en) begin
                        // Leaving EDIT overrides any step or toggle this cycle.
                        state    <= IDLE;
                        edit_q   <= 1'b0;
                        hold_cnt <= '0;
`ifdef THRESHOLD_SHADOW_COMMIT_EN
                        thr_q    <= shadow;
`endif
                    end else begin
                        if (do_step) begin
`ifdef THRESHOLD_SHADOW_COMMIT_EN
                            shadow <= stepped;
`else
                            thr_q  <= stepped;
`endif
                        end
                        if (bus.unit_toggle_press_once) begin
                            sel_q <= (sel_q == SEL_W'(N_FIELDS - 1)) ? '0 : sel_q + SEL_W'(1);
                        end
                        if (one_held && !bus.unit_toggle_press_once) begin
                            hold_cnt <= (hold_cnt == 16'(REPEAT_DELAY + REPEAT_RATE)) ?
                                        16'(REPEAT_DELAY + 1) : hold_cnt + 16'd1;
                        end else begin
                            hold_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_threshold_editor.sv
// Directed bench for threshold_editor: u0 built with CARRY_MODE=0, u1 with
// CARRY_MODE=1, both driven by identical stimulus. Expected values are
// hand-computed H:M:S triples packed 6/6/6.
module tb_threshold_editor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adjust_en = 1'b0;
    logic        toggle = 1'b0;
    logic        inc_p = 1'b0;
    logic        dec_p = 1'b0;
    logic        inc_h = 1'b0;
    logic        dec_h = 1'b0;
    logic        load_en = 1'b0;
    logic [17:0] load_value = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    threshold_editor_if #(.N_FIELDS(3), .FIELD_W(6)) bus0 ();
    threshold_editor_if #(.N_FIELDS(3), .FIELD_W(6)) bus1 ();

    assign bus0.adjust_en = adjust_en;
    assign bus0.unit_toggle_press_once = toggle;
    assign bus0.inc_press_once = inc_p;
    assign bus0.dec_press_once = dec_p;
    assign bus0.inc_held = inc_h;
    assign bus0.dec_held = dec_h;
    assign bus0.load_en = load_en;
    assign bus0.load_value = load_value;
    assign bus1.adjust_en = adjust_en;
    assign bus1.unit_toggle_press_once = toggle;
    assign bus1.inc_press_once = inc_p;
    assign bus1.dec_press_once = dec_p;
    assign bus1.inc_held = inc_h;
    assign bus1.dec_held = dec_h;
    assign bus1.load_en = load_en;
    assign bus1.load_value = load_value;

    threshold_editor #(.CARRY_MODE(0)) u0 (.clk_100Hz(clk), .rst(rst), .bus(bus0));
    threshold_editor #(.CARRY_MODE(1)) u1 (.clk_100Hz(clk), .rst(rst), .bus(bus1));

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        logic [17:0] p;
        p = {6'(h), 6'(m), 6'(s)};
        return 32'(p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs were set before it, pulses are cleared after it.
    task automatic tick();
        @(posedge clk);
        #1;
        toggle  = 1'b0;
        inc_p   = 1'b0;
        dec_p   = 1'b0;
        load_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_thr", 32'(bus0.threshold), 32'h40);
        check("reset_sel", 32'(bus0.field_sel), 32'd0);
        check("reset_editing", 32'(bus0.editing), 32'd0);
        rst = 1'b0;
        tick();
        check("post_release_thr", 32'(bus0.threshold), hms(0, 1, 0));

        load_value = {6'd30, 6'd63, 6'd10};
        load_en = 1'b1;
        tick();
        check("load_clamp_u0", 32'(bus0.threshold), hms(23, 59, 10));
        check("load_clamp_u1", 32'(bus1.threshold), hms(23, 59, 10));

`ifdef THRESHOLD_SHADOW_COMMIT_EN
        load_value = {6'd0, 6'd1, 6'd0};
        load_en = 1'b1;
        tick();
        adjust_en = 1'b1;
        tick();
        check("enter_editing", 32'(bus0.editing), 32'd1);
        for (int k = 0; k < 3; k++) begin
            inc_p = 1'b1;
            tick();
            check("shadow_hidden", 32'(bus0.threshold), hms(0, 1, 0));
        end
        adjust_en = 1'b0;
        tick();
        check("shadow_commit_u0", 32'(bus0.threshold), hms(0, 1, 3));
        check("shadow_commit_u1", 32'(bus1.threshold), hms(0, 1, 3));
        check("shadow_exit_editing", 32'(bus0.editing), 32'd0);
`else
        load_value = {6'd0, 6'd1, 6'd59};
        load_en = 1'b1;
        tick();
        check("load_plain", 32'(bus0.threshold), hms(0, 1, 59));

        adjust_en = 1'b1;
        tick();
        check("enter_editing", 32'(bus0.editing), 32'd1);
        check("enter_sel", 32'(bus0.field_sel), 32'd0);

        inc_p = 1'b1;
        tick();
        check("inc_wrap_nocarry", 32'(bus0.threshold), hms(0, 1, 0));
        check("inc_wrap_carry", 32'(bus1.threshold), hms(0, 2, 0));

        dec_p = 1'b1;
        tick();
        check("dec_wrap_nocarry", 32'(bus0.threshold), hms(0, 1, 59));
        check("dec_wrap_borrow", 32'(bus1.threshold), hms(0, 1, 59));

        load_value = {6'd5, 6'd5, 6'd5};
        load_en = 1'b1;
        tick();
        check("load_in_edit_ignored", 32'(bus0.threshold), hms(0, 1, 59));

        toggle = 1'b1;
        tick();
        toggle = 1'b1;
        tick();
        check("sel_two", 32'(bus0.field_sel), 32'd2);
        dec_p = 1'b1;
        tick();
        check("hour_dec_wrap_u0", 32'(bus0.threshold), hms(23, 1, 59));
        check("hour_dec_wrap_u1", 32'(bus1.threshold), hms(23, 1, 59));
        toggle = 1'b1;
        tick();
        check("sel_wrap", 32'(bus0.field_sel), 32'd0);

        inc_p = 1'b1;
        dec_p = 1'b1;
        tick();
        check("inc_wins_u0", 32'(bus0.threshold), hms(23, 1, 0));
        check("inc_wins_u1", 32'(bus1.threshold), hms(23, 2, 0));

        toggle = 1'b1;
        inc_p = 1'b1;
        tick();
        check("toggle_step_old_u0", 32'(bus0.threshold), hms(23, 1, 1));
        check("toggle_step_old_u1", 32'(bus1.threshold), hms(23, 2, 1));
        check("toggle_step_sel", 32'(bus0.field_sel), 32'd1);
        toggle = 1'b1;
        tick();
        toggle = 1'b1;
        tick();
        check("sel_back_zero", 32'(bus0.field_sel), 32'd0);

        dec_p = 1'b1;
        tick();
        check("sec_to_zero", 32'(bus0.threshold), hms(23, 1, 0));

        for (int k = 0; k < 80; k++) begin
            inc_p = (k == 0);
            inc_h = 1'b1;
            tick();
            if (k inside {0, 49, 50, 59, 60, 69, 70, 79})
                check("repeat_sec", 32'(bus0.threshold),
                      hms(23, 1, 1 + int'(k >= 50) + int'(k >= 60) + int'(k >= 70)));
        end
        inc_h = 1'b0;
        repeat (30) tick();
        check("repeat_release_u0", 32'(bus0.threshold), hms(23, 1, 4));
        check("repeat_release_u1", 32'(bus1.threshold), hms(23, 2, 4));

        toggle = 1'b1;
        tick();
        adjust_en = 1'b0;
        inc_p = 1'b1;
        tick();
        check("exit_no_step", 32'(bus0.threshold), hms(23, 1, 4));
        check("exit_editing", 32'(bus0.editing), 32'd0);
        adjust_en = 1'b1;
        tick();
        check("reenter_sel_zero", 32'(bus0.field_sel), 32'd0);
        check("reenter_editing", 32'(bus0.editing), 32'd1);
`endif

        rst = 1'b1;
        #1;
        check("midedit_reset_thr", 32'(bus0.threshold), hms(0, 1, 0));
        check("midedit_reset_editing", 32'(bus0.editing), 32'd0);
        adjust_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/threshold_editor.md
Name: threshold_editor

Overview:
- Parametrised successor of the single-purpose H:M:S threshold setter.
- Edits N_FIELDS packed counters, each with its own modulus.
- Adds auto-repeat on held buttons, optional cascaded carry/borrow between fields, and bulk load while idle.
- Sits between the debounced button layer (press_once pulses plus held levels) and the timer/alarm comparators that consume the packed threshold.

Parameters:
- N_FIELDS, 3, number of editable fields; field 0 is least significant (seconds).
- FIELD_W, 6, bits per field.
- FIELD_MAX, {6'd23,6'd59,6'd59}, packed N_FIELDS*FIELD_W; inclusive maximum per field, field 0 in the LSBs.
- RESET_VAL, {6'd0,6'd1,6'd0}, packed reset value per field (0:01:00).
- REPEAT_DELAY, 50, cycles a button must be held before the first auto-repeat step (0.5 s at 100 Hz).
- REPEAT_RATE, 10, cycles between subsequent auto-repeat steps.
- CARRY_MODE, 0, 1 = wrap of field i carries/borrows into field i+1.

Ports:
- clk_100Hz  in  1  system tick clock.
- rst  in  1  asynchronous, active-high reset.
- adjust_en  in  1  level; high = editing permitted.
- unit_toggle_press_once  in  1  one-cycle pulse; advances the selected field.
- inc_press_once  in  1  one-cycle pulse; step +1.
- dec_press_once  in  1  one-cycle pulse; step -1.
- inc_held  in  1  debounced level of the increment button.
- dec_held  in  1  debounced level of the decrement button.
- load_en  in  1  one-cycle pulse; bulk load, honoured in IDLE only.
- load_value  in  N_FIELDS*FIELD_W  packed value for load.
- threshold  out  N_FIELDS*FIELD_W  packed threshold output.
- field_sel  out  clog2(N_FIELDS) (min 1)  index of the field being edited.
- editing  out  1  high while in EDIT.

Behaviour:
Reset:
- threshold = RESET_VAL, field_sel = 0, editing = 0.
- FSM goes to IDLE; repeat counter clears.
- Reset mid-edit discards all pending state.

FSM (registered, all transitions on clk_100Hz):
- IDLE -> EDIT when adjust_en = 1; field_sel <= 0 on entry.
- EDIT -> IDLE when adjust_en = 0. This has priority over every other input in that cycle, and no step is applied.
- editing = (state == EDIT), registered.

Field selection:
- In EDIT, unit_toggle_press_once sets field_sel <= field_sel+1, wrapping from N_FIELDS-1 to 0.

Steps:
- Applied in EDIT only, to the field selected at the start of the cycle.
- If toggle and step occur in the same cycle, the step lands on the old field, then the selection advances.
- inc and dec in the same cycle: inc wins.
- Increment: v == FIELD_MAX[i] -> v <= 0; otherwise v+1.
- Decrement: v == 0 -> v <= FIELD_MAX[i]; otherwise v-1.
- CARRY_MODE = 1: a wrap on field i applies the same-direction step to field i+1, cascading combinationally in one cycle.
- The top field wraps with no carry out. Example: 23:59:59 +1 on sec -> 00:00:00.
- CARRY_MODE = 0: no inter-field effect.

Auto-repeat:
- A 16-bit hold counter runs in EDIT while exactly one of inc_held/dec_held is high.
- It clears on release, when both are held, on a field toggle, or on leaving EDIT.
- The press_once pulse at cycle t gives the first step.
- Further steps occur at t+REPEAT_DELAY, then every REPEAT_RATE cycles while the button is still held.
- A repeat step and a press_once in the same cycle count as one step.

Load:
- load_en in IDLE: each field <= min(load_value field, FIELD_MAX[i]). Out-of-range fields clamp to the maximum.
- load_en in EDIT is ignored.

Output timing:
- threshold updates the cycle after the qualifying input; one-cycle latency.

Optional Feature:
- Macro: THRESHOLD_SHADOW_COMMIT_EN.
- Defined:
  - Edits go to a shadow register, which is copied from threshold on entry to EDIT.
  - threshold updates only on the EDIT -> IDLE transition, with the shadow copied in that same cycle.
  - Consumers never see intermediate values.
  - Reset clears the shadow to RESET_VAL.
- Undefined: threshold updates live on every step, as described under Behaviour.

Test Plan:
- Reset release: threshold = 0x000040 (0:01:00 packed 6/6/6), field_sel = 0, editing = 0; the first adjust_en-high cycle yields editing = 1 on the following cycle.
- EDIT, field 0 = 59: inc_press_once -> field 0 = 0. With CARRY_MODE = 1, field 1 goes 1 -> 2; with CARRY_MODE = 0, field 1 stays 1.
- field_sel = 2, hour = 0: dec_press_once -> hour = 23. A further unit_toggle wraps field_sel to 0.
- inc_press_once at t with inc_held held 80 cycles, sec starting at 0 -> steps at t, t+50, t+60, t+70; sec = 4. Release -> no further steps.
- IDLE, load_en with load_value = {6'd30,6'd63,6'd10} -> threshold = 30→23 clamp, 63→59 clamp, 10 (23:59:10). The same load issued in EDIT has no effect.
- THRESHOLD_SHADOW_COMMIT_EN defined: three inc presses on sec in EDIT leave threshold unchanged until adjust_en falls; the next cycle shows sec +3.
